// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: per-master request, grant and read-return bundle between the GPU masters and dram_arbiter
interface dram_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_MASTERS-1:0] i_req;
  logic [NUM_MASTERS-1:0] i_we;
  logic [NUM_MASTERS-1:0] i_last;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_addr;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_wdata;
  logic [NUM_MASTERS-1:0] o_gnt;
  logic [NUM_MASTERS-1:0] o_ack;
  logic [NUM_MASTERS-1:0] o_rvalid;
  logic [DATA_WIDTH-1:0] o_rdata;
  modport master (
    output i_req, i_we, i_last, i_addr, i_wdata,
    input  o_gnt, o_ack, o_rvalid, o_rdata
  );
  modport slave (
    input  i_req, i_we, i_last, i_addr, i_wdata,
    output o_gnt, o_ack, o_rvalid, o_rdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin burst arbiter onto one DRAM port with fixed-latency read-return routing
module dram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  dram_arbiter_if.slave m,
  output logic o_busy,
  output logic o_dram_en,
  output logic o_dram_we,
  output logic [ADDR_WIDTH-1:0] o_dram_addr,
  output logic [DATA_WIDTH-1:0] o_dram_wdata,
  input  logic [DATA_WIDTH-1:0] i_dram_rdata
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_next;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [IW-1:0] r_ptr, r_gidx, w_sel, w_idx;
  logic [CW-1:0] r_cnt;
  logic [RD_LATENCY-1:0] r_tv;
  logic [RD_LATENCY-1:0][IW-1:0] r_tid;
  logic w_beat, w_rel;
  always_comb begin
    w_sel = r_ptr;
    w_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NUM_MASTERS);
      if (m.i_req[w_idx]) w_sel = w_idx;
    end
  end
  assign w_beat = !rst && r_state == BURST && m.i_req[r_gidx];
  assign w_rel = r_state == BURST && (!m.i_req[r_gidx] || m.i_last[r_gidx] || r_cnt == CW'(MAX_BURST - 1));
  assign w_next = r_state == IDLE ? (|m.i_req ? BURST : IDLE) : (w_rel ? IDLE : BURST);
  assign m.o_gnt = r_gnt;
  assign m.o_ack = w_beat ? r_gnt : '0;
  assign o_dram_en = w_beat;
  assign o_dram_we = w_beat & m.i_we[r_gidx];
  assign o_dram_addr = w_beat ? m.i_addr[r_gidx] : '0;
  assign o_dram_wdata = w_beat ? m.i_wdata[r_gidx] : '0;
  assign m.o_rvalid = !rst && r_tv[RD_LATENCY-1] ? NUM_MASTERS'(1) << r_tid[RD_LATENCY-1] : '0;
  assign m.o_rdata = i_dram_rdata;
  assign o_busy = !rst && (r_state == BURST || |r_tv);
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
      r_gidx <= '0;
      r_cnt <= '0;
      r_tv <= '0;
      r_tid <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |m.i_req) begin
        r_gnt <= NUM_MASTERS'(1) << w_sel;
        r_gidx <= w_sel;
        r_cnt <= '0;
      end else if (w_rel) begin
        r_gnt <= '0;
        r_ptr <= r_gidx == IW'(NUM_MASTERS - 1) ? '0 : r_gidx + IW'(1);
      end
      if (w_beat) r_cnt <= r_cnt + CW'(1);
      r_tv[0] <= w_beat && !m.i_we[r_gidx];
      r_tid[0] <= r_gidx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_tv[k] <= r_tv[k-1];
        r_tid[k] <= r_tid[k-1];
      end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: randomized scoreboard bench for dram_arbiter against a cycle-level behavioural model
module tb_dram_arbiter;
  localparam int N = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int LAT = 3;
  typedef struct { logic [N-1:0] gnt; logic [N-1:0] ack; logic [N-1:0] rvalid; logic busy; } cyc_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } beat_t;
  typedef struct { int due; int id; logic [DW-1:0] data; } pend_t;
  typedef struct { int id; logic [DW-1:0] data; } rd_t;
  logic clk = 0;
  logic rst = 1;
  logic busy, den, dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] drdata = '0;
  int vectors = 0;
  int miscompares = 0;
  cyc_t cyc_q[$];
  beat_t beat_q[$];
  rd_t read_q[$];
  pend_t pend[$];
  int g = -1;
  int ptr = 0;
  int cnt = 0;
  int cycle = 0;
  dram_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dram_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .RD_LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .m(bus.slave),
    .o_busy(busy),
    .o_dram_en(den),
    .o_dram_we(dwe),
    .o_dram_addr(daddr),
    .o_dram_wdata(dwdata),
    .i_dram_rdata(drdata)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a + 32'h1;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
    end
  endtask
  task automatic step(input int preq, input int plast, input bit r);
    cyc_t c;
    pend_t p;
    bit beat;
    @(posedge clk);
    #1;
    rst = r;
    for (int i = 0; i < N; i++) begin
      bus.i_req[i] = $urandom_range(99) < preq;
      bus.i_we[i] = 1'($urandom_range(1));
      bus.i_last[i] = $urandom_range(99) < plast;
      bus.i_addr[i] = $urandom & 32'hffff_fffc;
      bus.i_wdata[i] = $urandom;
    end
    c.gnt = g < 0 ? '0 : N'(1) << g;
    beat = !r && g >= 0 && bus.i_req[g];
    c.ack = beat ? c.gnt : '0;
    c.busy = !r && (g >= 0 || pend.size() > 0);
    c.rvalid = '0;
    drdata = $urandom;
    if (pend.size() > 0 && pend[0].due == cycle) begin
      p = pend.pop_front();
      drdata = p.data;
      if (!r) begin
        c.rvalid = N'(1) << p.id;
        read_q.push_back('{p.id, p.data});
      end
    end
    if (beat) beat_q.push_back('{bus.i_we[g], bus.i_addr[g], bus.i_wdata[g]});
    cyc_q.push_back(c);
    if (r) begin
      g = -1;
      ptr = 0;
      cnt = 0;
      pend.delete();
    end else if (g < 0) begin
      for (int k = 0; k < N; k++)
        if (bus.i_req[(ptr + k) % N]) begin
          g = (ptr + k) % N;
          cnt = 0;
          break;
        end
    end else if (!bus.i_req[g]) begin
      ptr = (g + 1) % N;
      g = -1;
    end else begin
      if (!bus.i_we[g]) pend.push_back('{cycle + LAT, g, mem(bus.i_addr[g])});
      cnt++;
      if (bus.i_last[g] || cnt == MB) begin
        ptr = (g + 1) % N;
        g = -1;
      end
    end
    cycle++;
  endtask
  initial begin : mon
    cyc_t c;
    beat_t b;
    rd_t rd;
    forever begin
      @(negedge clk);
      if (cyc_q.size() == 0) continue;
      c = cyc_q.pop_front();
      chk("gnt", 64'(bus.o_gnt), 64'(c.gnt));
      chk("ack", 64'(bus.o_ack), 64'(c.ack));
      chk("rvalid", 64'(bus.o_rvalid), 64'(c.rvalid));
      chk("busy", 64'(busy), 64'(c.busy));
      chk("dram_en", 64'(den), 64'(|c.ack));
      if (den) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 64'(den), 64'(0));
        else begin
          b = beat_q.pop_front();
          chk("dram_we", 64'(dwe), 64'(b.we));
          chk("dram_addr", 64'(daddr), 64'(b.addr));
          chk("dram_wdata", 64'(dwdata), 64'(b.wdata));
        end
      end else chk("dram_idle_bus", {31'(0), dwe, daddr}, 64'(0));
      if (|bus.o_rvalid) begin
        if (read_q.size() == 0) chk("rvalid_unexpected", 64'(bus.o_rvalid), 64'(0));
        else begin
          rd = read_q.pop_front();
          chk("rdata", 64'(bus.o_rdata), 64'(rd.data));
        end
      end
    end
  end
  initial begin
    bus.i_req = '0;
    bus.i_we = '0;
    bus.i_last = '0;
    bus.i_addr = '0;
    bus.i_wdata = '0;
    repeat (2) step(100, 0, 1);
    repeat (12) step(100, 100, 0);
    repeat (40) step(100, 0, 0);
    repeat (3000) step($urandom_range(2) == 0 ? 30 : ($urandom_range(1) ? 70 : 95), 30, $urandom_range(99) == 0);
    repeat (2) step(100, 0, 1);
    repeat (12) step(0, 0, 0);
    repeat (2) @(negedge clk);
    chk("beat_q_drained", 64'(beat_q.size()), 64'(0));
    chk("read_q_drained", 64'(read_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
